// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-specifier width, mux3 forward-select
// codes and the shadow-slot records kept by the hazard tracker.
package riscv_pipe_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic             load;
   } e_slot_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
   } mw_slot_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// Pipeline <-> hazard tracker bundle: ID-stage specifiers and branch resolution
// in, forwarding selects, stall/flush controls and event counters out.
interface hazard_tracker_if #(
   parameter int CNT_W = 16
);
   import riscv_pipe_pkg::*;

   logic [REG_W-1:0] Rs1D;
   logic [REG_W-1:0] Rs2D;
   logic [REG_W-1:0] RdD;
   logic             RegWriteD;
   logic             LoadD;
   logic             PCSrcE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
      input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE,
      output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
      output stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_tracker_fwd_sel.sv
// Forward select for one EX operand: MEM result beats WB result, and x0 is
// never forwarded because its architectural value is always zero.
module fwd_sel
   import riscv_pipe_pkg::*;
(
   input  logic [REG_W-1:0] src_i,
   input  mw_slot_t         m_i,
   input  mw_slot_t         w_i,
   output logic [1:0]       sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (w_i.valid && w_i.regwrite && (w_i.rd != '0) && (w_i.rd == src_i))
         sel_o = FWD_WB;
      if (m_i.valid && m_i.regwrite && (m_i.rd != '0) && (m_i.rd == src_i))
         sel_o = FWD_MEM;
   end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard controller for the 5-stage core: shadows E/M/W specifiers, drives the
// EX forwarding selects, load-use stall, branch flushes and saturating counters.
module hazard_tracker
   import riscv_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   hazard_tracker_if.slave hz
);

   logic             d_valid_q, d_valid_d;
   e_slot_t          e_q, e_d;
   mw_slot_t         m_q, m_d;
   mw_slot_t         w_q, w_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic       lu;
   logic       stall;
   logic       flush_d;
   logic       flush_e;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   fwd_sel u_fwd_a (.src_i(e_q.rs1), .m_i(m_q), .w_i(w_q), .sel_o(fwd_a));
   fwd_sel u_fwd_b (.src_i(e_q.rs2), .m_i(m_q), .w_i(w_q), .sel_o(fwd_b));

   // A taken branch dominates a load-use hazard: the dependent instruction is
   // squashed anyway, so stalling would only waste a cycle.
   assign lu      = e_q.valid && e_q.load && (e_q.rd != '0) && d_valid_q &&
                    ((e_q.rd == hz.Rs1D) || (e_q.rd == hz.Rs2D));
   assign stall   = lu && !hz.PCSrcE;
   assign flush_e = lu || hz.PCSrcE;
   assign flush_d = hz.PCSrcE;

   always_comb begin
      e_d = '0;
      if (!flush_e && d_valid_q)
         e_d = '{valid: 1'b1, rs1: hz.Rs1D, rs2: hz.Rs2D, rd: hz.RdD,
                 regwrite: hz.RegWriteD, load: hz.LoadD};
      m_d = '{valid: e_q.valid, rd: e_q.rd, regwrite: e_q.regwrite};
      w_d = m_q;
      if (flush_d)
         d_valid_d = 1'b0;
      else if (stall)
         d_valid_d = d_valid_q;
      else
         d_valid_d = 1'b1;
      stall_cnt_d = stall   ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush_d ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_valid_q   <= 1'b0;
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         d_valid_q   <= d_valid_d;
         e_q         <= e_d;
         m_q         <= m_d;
         w_q         <= w_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While in reset the pipeline registers are held cleared and nothing forwards.
   always_comb begin
      hz.ForwardAE = rst_n ? fwd_a : FWD_RF;
      hz.ForwardBE = rst_n ? fwd_b : FWD_RF;
      hz.StallF    = rst_n && stall;
      hz.StallD    = rst_n && stall;
      hz.FlushD    = !rst_n || flush_d;
      hz.FlushE    = !rst_n || flush_e;
      hz.stall_cnt = stall_cnt_q;
      hz.flush_cnt = flush_cnt_q;
   end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed hazard scenarios and random traffic, with
// two DUTs (16-bit and 4-bit counters) sharing stimulus and checked each cycle.
module tb_hazard_tracker;
   import riscv_pipe_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_tracker_if #(.CNT_W(16)) h16 ();
   hazard_tracker_if #(.CNT_W(4))  h4  ();

   assign h4.Rs1D      = h16.Rs1D;
   assign h4.Rs2D      = h16.Rs2D;
   assign h4.RdD       = h16.RdD;
   assign h4.RegWriteD = h16.RegWriteD;
   assign h4.LoadD     = h16.LoadD;
   assign h4.PCSrcE    = h16.PCSrcE;

   hazard_tracker #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .hz(h16));
   hazard_tracker #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .hz(h4));

   // Instructions in flight, oldest last: index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit v;
      int rs1;
      int rs2;
      int rd;
      bit rw;
      bit ld;
   } ins_t;

   ins_t pipe [3];
   bit   id_live;
   int   scnt16, fcnt16, scnt4, fcnt4;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   x_ae, x_be;
   bit   x_stall, x_fd, x_fe;

   function automatic int fwd_of(input int src);
      for (int k = 1; k <= 2; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src)
            return (k == 1) ? 2 : 1;
      return 0;
   endfunction

   function automatic bit load_use();
      return pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && id_live &&
             (pipe[0].rd == int'(h16.Rs1D) || pipe[0].rd == int'(h16.Rs2D));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic predict();
      if (!rst_n) begin
         x_ae = 0; x_be = 0; x_stall = 0; x_fd = 1; x_fe = 1;
      end else begin
         x_ae    = fwd_of(int'(h16.Rs1D) * 0 + pipe[0].rs1);
         x_be    = fwd_of(pipe[0].rs2);
         x_stall = load_use() && !h16.PCSrcE;
         x_fd    = h16.PCSrcE;
         x_fe    = load_use() || h16.PCSrcE;
      end
   endtask

   task automatic compare_cycle();
      predict();
      chk("ForwardAE16", int'(h16.ForwardAE), x_ae);
      chk("ForwardBE16", int'(h16.ForwardBE), x_be);
      chk("StallF16",    int'(h16.StallF),    int'(x_stall));
      chk("StallD16",    int'(h16.StallD),    int'(x_stall));
      chk("FlushD16",    int'(h16.FlushD),    int'(x_fd));
      chk("FlushE16",    int'(h16.FlushE),    int'(x_fe));
      chk("stall_cnt16", int'(h16.stall_cnt), scnt16);
      chk("flush_cnt16", int'(h16.flush_cnt), fcnt16);
      chk("ForwardAE4",  int'(h4.ForwardAE),  x_ae);
      chk("StallD4",     int'(h4.StallD),     int'(x_stall));
      chk("FlushE4",     int'(h4.FlushE),     int'(x_fe));
      chk("stall_cnt4",  int'(h4.stall_cnt),  scnt4);
      chk("flush_cnt4",  int'(h4.flush_cnt),  fcnt4);
   endtask

   task automatic advance();
      bit lu, pc, st;
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
         id_live = 0;
         scnt16 = 0; fcnt16 = 0; scnt4 = 0; fcnt4 = 0;
      end else begin
         lu = load_use();
         pc = h16.PCSrcE;
         st = lu && !pc;
         if (st) begin
            scnt16 = (scnt16 < 65535) ? scnt16 + 1 : scnt16;
            scnt4  = (scnt4  < 15)    ? scnt4  + 1 : scnt4;
         end
         if (pc) begin
            fcnt16 = (fcnt16 < 65535) ? fcnt16 + 1 : fcnt16;
            fcnt4  = (fcnt4  < 15)    ? fcnt4  + 1 : fcnt4;
         end
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (lu || pc || !id_live)
            pipe[0] = '{default: 0};
         else
            pipe[0] = '{1, int'(h16.Rs1D), int'(h16.Rs2D), int'(h16.RdD),
                        h16.RegWriteD, h16.LoadD};
         if (pc)       id_live = 0;
         else if (!st) id_live = 1;
      end
   endtask

   task automatic set_in(input int rs1, input int rs2, input int rd,
                         input bit rw, input bit ld, input bit pc);
      h16.Rs1D      = REG_W'(rs1);
      h16.Rs2D      = REG_W'(rs2);
      h16.RdD       = REG_W'(rd);
      h16.RegWriteD = rw;
      h16.LoadD     = ld;
      h16.PCSrcE    = pc;
   endtask

   task automatic at_neg();
      @(negedge clk);
      compare_cycle();
   endtask

   task automatic at_pos();
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic cyc(input int rs1, input int rs2, input int rd,
                      input bit rw, input bit ld, input bit pc);
      set_in(rs1, rs2, rd, rw, ld, pc);
      at_neg();
      at_pos();
   endtask

   task automatic nop();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      id_live = 0;
      scnt16 = 0; fcnt16 = 0; scnt4 = 0; fcnt4 = 0;

      // Reset: forced control outputs, then counters cleared.
      rst_n = 1'b0;
      set_in(5, 5, 5, 1, 1, 0);
      at_neg();
      chk("rst_FlushD", int'(h16.FlushD), 1);
      chk("rst_FlushE", int'(h16.FlushE), 1);
      chk("rst_StallF", int'(h16.StallF), 0);
      chk("rst_FwdA",   int'(h16.ForwardAE), 0);
      at_pos();
      nop();
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("rst_stall_cnt", int'(h16.stall_cnt), 0);
      chk("rst_flush_cnt", int'(h16.flush_cnt), 0);
      at_pos();

      // MEM forward: add x5 ; sub x8, x5, x6.
      cyc(1, 2, 5, 1, 0, 0);
      cyc(5, 6, 8, 1, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("mem_fwd_A", int'(h16.ForwardAE), 2);
      chk("mem_fwd_B", int'(h16.ForwardBE), 0);
      at_pos();

      // Two writers of x7 then a reader: the younger (MEM) wins.
      cyc(1, 2, 7, 1, 0, 0);
      cyc(3, 4, 7, 1, 0, 0);
      cyc(7, 9, 10, 1, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("mem_prio_A", int'(h16.ForwardAE), 2);
      at_pos();

      // Reader two slots behind a single writer: WB forward.
      cyc(1, 2, 11, 1, 0, 0);
      nop();
      cyc(1, 11, 12, 1, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("wb_fwd_B", int'(h16.ForwardBE), 1);
      at_pos();

      // Writer to x0 followed by a reader of x0.
      cyc(1, 2, 0, 1, 0, 0);
      cyc(0, 0, 13, 1, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("x0_A", int'(h16.ForwardAE), 0);
      chk("x0_B", int'(h16.ForwardBE), 0);
      at_pos();

      // Load-use: lw x3 ; reader with rs2 = x3.
      cyc(1, 2, 3, 1, 1, 0);
      set_in(4, 3, 4, 1, 0, 0);
      at_neg();
      chk("lu_StallF", int'(h16.StallF), 1);
      chk("lu_StallD", int'(h16.StallD), 1);
      chk("lu_FlushE", int'(h16.FlushE), 1);
      chk("lu_FlushD", int'(h16.FlushD), 0);
      at_pos();
      at_neg();
      chk("lu_once",      int'(h16.StallD), 0);
      chk("lu_stall_cnt", int'(h16.stall_cnt), 1);
      at_pos();
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("lu_wb_fwd_B", int'(h16.ForwardBE), 1);
      at_pos();

      // Taken branch alone; the instruction fetched behind it is discarded.
      set_in(0, 0, 0, 0, 0, 1);
      at_neg();
      chk("br_FlushD", int'(h16.FlushD), 1);
      chk("br_FlushE", int'(h16.FlushE), 1);
      chk("br_StallF", int'(h16.StallF), 0);
      at_pos();
      set_in(1, 2, 12, 1, 0, 0);
      at_neg();
      chk("br_flush_cnt", int'(h16.flush_cnt), 1);
      at_pos();
      cyc(12, 0, 14, 1, 0, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("br_dropped_A", int'(h16.ForwardAE), 0);
      at_pos();

      // Taken branch together with a load-use hazard.
      cyc(1, 2, 3, 1, 1, 0);
      set_in(3, 0, 5, 1, 0, 1);
      at_neg();
      chk("brlu_StallD", int'(h16.StallD), 0);
      chk("brlu_FlushE", int'(h16.FlushE), 1);
      chk("brlu_FlushD", int'(h16.FlushD), 1);
      at_pos();
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("brlu_stall_cnt", int'(h16.stall_cnt), 1);
      chk("brlu_flush_cnt", int'(h16.flush_cnt), 2);
      at_pos();

      // Reset while a MEM forward is live.
      cyc(1, 2, 13, 1, 0, 0);
      cyc(13, 0, 6, 1, 0, 0);
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("mid_rst_A", int'(h16.ForwardAE), 0);
      at_pos();
      rst_n = 1'b1;
      at_neg();
      chk("post_rst_A",         int'(h16.ForwardAE), 0);
      chk("post_rst_stall_cnt", int'(h16.stall_cnt), 0);
      chk("post_rst_flush_cnt", int'(h16.flush_cnt), 0);
      at_pos();

      // Back-to-back dependent loads stall every other cycle; 4-bit counter saturates.
      for (int i = 0; i < 39; i++) cyc(3, 0, 3, 1, 1, 0);
      set_in(0, 0, 0, 0, 0, 0);
      at_neg();
      chk("sat_stall_cnt4",  int'(h4.stall_cnt),  15);
      chk("sat_stall_cnt16", int'(h16.stall_cnt), 19);
      at_pos();

      // Random traffic over a small register range to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 79) != 0);
         cyc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
